// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: programmable half-period, all four CPOL/CPHA
// modes, exactly N SCLK cycles per transfer with sample/shift strobes.
module spi_sclk_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [DIV_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_nbits,
  input  logic             i_cpol,
  input  logic             i_cpha,
  output logic             o_sclk,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sample,
  output logic             o_shift,
  output logic [CNT_W-1:0] o_bit_idx
);

  localparam int EW = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [DIV_W-1:0] hcnt_q, hcnt_d;
  logic [EW-1:0]    edge_q, edge_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sample_q, sample_d;
  logic             shift_q, shift_d;
  logic [CNT_W-1:0] bidx_q, bidx_d;

  logic start_ok;
  logic hc_tc;
  logic last_edge;
  logic leading;

  assign start_ok  = i_start && (i_nbits != '0);
  assign hc_tc     = (hcnt_q == div_q);
  assign last_edge = (edge_q == ({nbits_q, 1'b0} - EW'(1)));
  // edge_q holds edges already emitted, so an even count means the next is odd
  assign leading   = ~edge_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      nbits_q  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      hcnt_q   <= '0;
      edge_q   <= '0;
      sclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      bidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      nbits_q  <= nbits_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      hcnt_q   <= hcnt_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      bidx_q   <= bidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = RUN;
      RUN: begin
        if (i_abort) state_d = IDLE;
        else if (hc_tc && last_edge) state_d = TAIL;
      end
      TAIL: begin
        if (i_abort) state_d = IDLE;
        else if (hc_tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d    = div_q;
    nbits_d  = nbits_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    hcnt_d   = hcnt_q;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    busy_d   = busy_q;
    bidx_d   = bidx_q;
    done_d   = 1'b0;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          div_d   = i_div;
          nbits_d = i_nbits;
          cpol_d  = i_cpol;
          cpha_d  = i_cpha;
          sclk_d  = i_cpol;
          bidx_d  = '0;
          hcnt_d  = '0;
          edge_d  = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (i_abort) begin
          sclk_d = cpol_q;
          busy_d = 1'b0;
        end else if (hc_tc) begin
          hcnt_d   = '0;
          sclk_d   = ~sclk_q;
          edge_d   = edge_q + EW'(1);
          sample_d = leading ^ cpha_q;
          shift_d  = ~(leading ^ cpha_q);
          if (!leading) bidx_d = bidx_q + CNT_W'(1);
        end else begin
          hcnt_d = hcnt_q + DIV_W'(1);
        end
      end
      TAIL: begin
        if (i_abort) begin
          sclk_d = cpol_q;
          busy_d = 1'b0;
        end else if (hc_tc) begin
          hcnt_d = '0;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          hcnt_d = hcnt_q + DIV_W'(1);
        end
      end
      default: begin
        sclk_d = cpol_q;
        busy_d = 1'b0;
      end
    endcase
  end

  assign o_sclk    = sclk_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_sample  = sample_q;
  assign o_shift   = shift_q;
  assign o_bit_idx = bidx_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: timeline model checked every cycle plus
// hand-computed literal checkpoints for each directed scenario.
module tb_spi_sclk_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [7:0] i_div = '0;
  logic [5:0] i_nbits = '0;
  logic       i_cpol = 1'b0;
  logic       i_cpha = 1'b0;
  logic       o_sclk, o_busy, o_done, o_sample, o_shift;
  logic [5:0] o_bit_idx;

  int checks = 0;
  int passes = 0;

  spi_sclk_gen #(.DIV_W(8), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_start(i_start), .i_abort(i_abort),
    .i_div(i_div), .i_nbits(i_nbits),
    .i_cpol(i_cpol), .i_cpha(i_cpha),
    .o_sclk(o_sclk), .o_busy(o_busy), .o_done(o_done),
    .o_sample(o_sample), .o_shift(o_shift),
    .o_bit_idx(o_bit_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sclk;
    logic       busy;
    logic       done;
    logic       sample;
    logic       shift;
    logic [5:0] bidx;
  } exp_t;

  // Transfer timeline model: everything derives from cycles since T0.
  int   cyc = 0;
  logic m_valid = 1'b0;
  int   m_t0 = 0;
  int   m_h = 1;
  int   m_n = 0;
  logic m_cpol = 1'b0;
  logic m_cpha = 1'b0;
  logic m_aborted = 1'b0;
  int   m_abort_cyc = 0;
  logic [5:0] m_abort_bidx = '0;

  function automatic exp_t exp_at(input int c);
    exp_t e;
    int r, k, tot;
    logic lead;
    e = '0;
    e.sclk = m_cpol;
    if (!m_valid) return e;
    if (m_aborted && c >= m_abort_cyc) begin
      e.bidx = m_abort_bidx;
      return e;
    end
    r = c - m_t0;
    tot = (2 * m_n + 1) * m_h;
    if (r < tot) begin
      k = r / m_h;
      e.busy = 1'b1;
      e.sclk = m_cpol ^ (k % 2 == 1);
      e.bidx = 6'(k / 2);
      if (k >= 1 && (r % m_h) == 0) begin
        lead = (k % 2 == 1);
        e.sample = lead ^ m_cpha;
        e.shift = ~(lead ^ m_cpha);
      end
    end else begin
      e.bidx = 6'(m_n);
      e.done = (r == tot);
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_cpol = 1'b0;
      m_aborted = 1'b0;
    end else begin
      e = exp_at(cyc);
      cyc = cyc + 1;
      if (!e.busy) begin
        if (i_start && i_nbits != 0) begin
          m_valid = 1'b1;
          m_t0 = cyc;
          m_h = int'(i_div) + 1;
          m_n = int'(i_nbits);
          m_cpol = i_cpol;
          m_cpha = i_cpha;
          m_aborted = 1'b0;
        end
      end else if (i_abort) begin
        m_aborted = 1'b1;
        m_abort_cyc = cyc;
        m_abort_bidx = e.bidx;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e, a;
    e = exp_at(cyc);
    a = {o_sclk, o_busy, o_done, o_sample, o_shift, o_bit_idx};
    checks = checks + 1;
    if (a === e) passes = passes + 1;
    else $display("FAIL model cyc=%0d actual=%b required=%b (sclk,busy,done,sample,shift,bidx)",
                  cyc, a, e);
  end

  task automatic chk(input string nm, input logic a, input logic x);
    checks = checks + 1;
    if (a === x) passes = passes + 1;
    else $display("FAIL %s actual=%b required=%b", nm, a, x);
  endtask

  task automatic chkv(input string nm, input logic [5:0] a, input logic [5:0] x);
    checks = checks + 1;
    if (a === x) passes = passes + 1;
    else $display("FAIL %s actual=%0d required=%0d", nm, a, x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench at T0+1ns with i_start released.
  task automatic start_xfer(input logic [7:0] d, input logic [5:0] n,
                            input logic cp, input logic ch);
    i_div = d;
    i_nbits = n;
    i_cpol = cp;
    i_cpha = ch;
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  initial begin
    step(3);
    chk("rst_sclk", o_sclk, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chkv("rst_bidx", o_bit_idx, 6'd0);
    rst_n = 1'b1;
    step(2);

    // mode 0, H=2, 8 bits
    start_xfer(8'd1, 6'd8, 1'b0, 1'b0);
    chk("m0_busy_t0", o_busy, 1'b1);
    step(2);
    chk("m0_rise1", o_sclk, 1'b1);
    chk("m0_samp1", o_sample, 1'b1);
    chk("m0_shift1", o_shift, 1'b0);
    step(2);
    chk("m0_fall1", o_sclk, 1'b0);
    chk("m0_shift2", o_shift, 1'b1);
    chkv("m0_bidx1", o_bit_idx, 6'd1);
    step(28);
    chkv("m0_bidx8", o_bit_idx, 6'd8);
    chk("m0_sclk32", o_sclk, 1'b0);
    step(1);
    chk("m0_nodone33", o_done, 1'b0);
    chk("m0_busy33", o_busy, 1'b1);
    step(1);
    chk("m0_done34", o_done, 1'b1);
    chk("m0_idle34", o_busy, 1'b0);
    step(1);
    chk("m0_done35", o_done, 1'b0);
    step(2);

    // mode 3, H=1, 3 bits
    start_xfer(8'd0, 6'd3, 1'b1, 1'b1);
    chk("m3_idle1", o_sclk, 1'b1);
    step(1);
    chk("m3_fall1", o_sclk, 1'b0);
    chk("m3_shift1", o_shift, 1'b1);
    chk("m3_nosamp1", o_sample, 1'b0);
    step(1);
    chk("m3_samp2", o_sample, 1'b1);
    chkv("m3_bidx2", o_bit_idx, 6'd1);
    step(4);
    chk("m3_samp6", o_sample, 1'b1);
    chkv("m3_bidx6", o_bit_idx, 6'd3);
    step(1);
    chk("m3_done7", o_done, 1'b1);
    step(2);

    // mode 1, H=256, 1 bit
    start_xfer(8'hFF, 6'd1, 1'b0, 1'b1);
    step(255);
    chk("m1_sclk255", o_sclk, 1'b0);
    step(1);
    chk("m1_rise256", o_sclk, 1'b1);
    chk("m1_shift256", o_shift, 1'b1);
    step(256);
    chk("m1_fall512", o_sclk, 1'b0);
    chk("m1_samp512", o_sample, 1'b1);
    step(255);
    chk("m1_busy767", o_busy, 1'b1);
    chk("m1_nodone767", o_done, 1'b0);
    step(1);
    chk("m1_done768", o_done, 1'b1);
    step(2);

    // back-to-back
    start_xfer(8'd0, 6'd1, 1'b0, 1'b0);
    step(3);
    chk("b2b_done_a", o_done, 1'b1);
    start_xfer(8'd0, 6'd2, 1'b0, 1'b0);
    chk("b2b_busy_b", o_busy, 1'b1);
    chkv("b2b_bidx0", o_bit_idx, 6'd0);
    step(5);
    chk("b2b_done_b", o_done, 1'b1);
    chkv("b2b_bidx2", o_bit_idx, 6'd2);
    step(2);

    // abort after edge 5; stray starts ignored
    start_xfer(8'd1, 6'd8, 1'b0, 1'b0);
    step(4);
    i_start = 1'b1;
    i_nbits = 6'd1;
    step(1);
    i_start = 1'b0;
    step(5);
    chk("ab_edge5", o_sclk, 1'b1);
    i_abort = 1'b1;
    step(1);
    i_abort = 1'b0;
    chk("ab_busy", o_busy, 1'b0);
    chk("ab_sclk", o_sclk, 1'b0);
    chkv("ab_bidx", o_bit_idx, 6'd2);
    step(3);
    chk("ab_nodone", o_done, 1'b0);
    i_nbits = 6'd0;
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    chk("n0_ignored", o_busy, 1'b0);
    step(2);
    i_abort = 1'b1;
    start_xfer(8'd0, 6'd1, 1'b0, 1'b0);
    i_abort = 1'b0;
    chk("ab_start_idle", o_busy, 1'b1);
    step(5);

    // reset mid-transfer, mode 2
    start_xfer(8'd2, 6'd4, 1'b1, 1'b0);
    step(7);
    chk("m2_sclk7", o_sclk, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_sclk", o_sclk, 1'b0);
    chk("rr_busy", o_busy, 1'b0);
    chkv("rr_bidx", o_bit_idx, 6'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    start_xfer(8'd3, 6'd2, 1'b1, 1'b0);
    chk("m2_idle_hi", o_sclk, 1'b1);
    step(4);
    chk("m2_fall1", o_sclk, 1'b0);
    chk("m2_samp1", o_sample, 1'b1);
    step(16);
    chk("m2_done20", o_done, 1'b1);
    chkv("m2_bidx", o_bit_idx, 6'd2);
    step(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
Parametrised SPI serial-clock generator. It is the successor to the fixed free-running divider.
- Divides clk by a runtime-programmable ratio.
- Supports all four SPI modes (CPOL/CPHA).
- Emits exactly N SCLK cycles per transfer under a start/busy/done handshake.
- Provides single-cycle sample/shift strobes to the SPI shift register.

Sits between the SPI master control FSM and the shift register / pad logic.

Parameters:
DIV_W, 8, width of divide-ratio input; half-period H = i_div+1 clk cycles (1..2^DIV_W)
CNT_W, 6, width of bit-count input/output; max bits per transfer = 2^CNT_W-1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_start  input  1  request transfer; accepted only when o_busy=0
i_abort  input  1  synchronous abort of a running transfer
i_div  input  DIV_W  half-period minus one, latched at start
i_nbits  input  CNT_W  bits per transfer N, latched at start; 0 = start ignored
i_cpol  input  1  SCLK idle level, latched at start
i_cpha  input  1  clock phase, latched at start
o_sclk  output  1  serial clock, registered
o_busy  output  1  transfer in progress
o_done  output  1  one-cycle pulse at normal completion
o_sample  output  1  one-cycle strobe on each sampling edge
o_shift  output  1  one-cycle strobe on each shifting edge
o_bit_idx  output  CNT_W  completed bits in current/last transfer

Behaviour:
Timing and reset
- All outputs registered.
- Reset (async, any time, including mid-transfer): state IDLE, o_sclk=0, o_busy=0, o_done=0, o_sample=0, o_shift=0, o_bit_idx=0, latched cpol/cpha/div/nbits=0, all counters 0.

States
- IDLE
- RUN
- TAIL

IDLE
- o_sclk = latched cpol.
- i_start=1 and i_nbits!=0 at edge T0: latch i_div, i_nbits, i_cpol, i_cpha; o_sclk<=i_cpol; o_bit_idx<=0; half-period counter<=0; edge counter<=0; o_busy<=1; go RUN.
- Changes on i_cpol while IDLE appear on o_sclk only at the next accepted start.
- i_start=1 with i_nbits=0: ignored.

RUN
- Half-period counter counts 0..H-1. At terminal count: counter<=0, o_sclk toggles, edge counter increments.
- Edge k (k=1..2N) is visible at T0+k*H.
- Odd edges are leading, even edges are trailing.
- CPHA=0: o_sample pulses with each leading edge, o_shift with each trailing edge.
- CPHA=1: o_shift pulses with each leading edge, o_sample with each trailing edge.
- Strobes assert in the same cycle the new o_sclk value appears.
- o_bit_idx increments on each trailing edge; reaches N after edge 2N.
- After edge 2N, o_sclk = cpol; go TAIL.

TAIL
- Wait one further half-period (H cycles).
- At T0+(2N+1)*H: o_done=1 for one cycle, o_busy=0, go IDLE.
- o_bit_idx holds N until the next accepted start.

Handshake
- i_start is ignored while o_busy=1.
- Back-to-back transfers are legal: a start sampled in the cycle o_done=1 is accepted, making the next T0 that edge.
- The latched div/nbits/cpol/cpha cannot be changed mid-transfer.

Abort
- i_abort=1 in RUN or TAIL: next cycle IDLE, o_sclk=cpol, o_busy=0, no o_done, no strobes.
- o_bit_idx holds its value at abort.
- i_abort in IDLE: no effect.
- If i_abort and i_start are asserted in the same IDLE cycle, start is accepted.

Width rules
- Edge counter is CNT_W+1 bits wide.
- H=1 (i_div=0) gives SCLK = clk/2 with strobes on consecutive edges.
- i_div=all-ones gives H=2^DIV_W with no overflow; the counter compares to latched i_div.

Test Plan:
- Mode 0, i_div=1, i_nbits=8, start at T0 -> o_busy 1 from T0+1; sclk rises T0+2,6,...,30 and falls T0+4,...,32; o_sample on rises, o_shift on falls; o_bit_idx=8; o_done at T0+34 only.
- Mode 3 (cpol=1,cpha=1), i_div=0, i_nbits=3 -> sclk idles 1; 6 edges at T0+1..T0+6 (falling first); o_shift at T0+1,3,5; o_sample at T0+2,4,6; o_done at T0+7.
- i_div=8'hFF, i_nbits=1, mode 1 -> edges at T0+256 and T0+512; o_done at T0+768; counter does not wrap early.
- Back-to-back: second i_start asserted during o_done cycle with i_nbits=2 -> accepted; no idle gap on o_busy beyond the done cycle; o_bit_idx restarts at 0.
- i_abort after edge 5 of an 8-bit mode-0 transfer -> next cycle o_busy=0, o_sclk=0, o_bit_idx=2, no o_done; i_start during busy and i_nbits=0 starts are both ignored.
- rst_n pulsed low mid-transfer in mode 2 -> all outputs 0 immediately (o_sclk=0); after release, a new mode-2 start drives o_sclk to 1 at T0+1 and runs normally.
